ula_arbiter: RTL and testbench
==============================

// Module: ula_arbiter
// PURPOSE
//  Shares one W-bit ALU (AND/OR/ADD/SUB with signed overflow) between N requesters.
//  Round-robin arbitration; operands are captured on grant and the op runs in one
//  registered cycle. Result returns on a single valid/ready bus tagged with the
//  requester index. Sits between client FSMs and the arithmetic datapath.
// PARAMETERS
//  W   8  operand/result width, two's complement
//  N   2  number of requesters (>=2)
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  rst_n      in   1       async active-low reset
//  req        in   N       req[i]=1: requester i has a valid op; hold until gnt[i]
//  op_a       in   N*W     operand A, slice i = op_a[i*W +: W]
//  op_b       in   N*W     operand B, same slicing
//  op_f       in   2*N     function, slice i = op_f[2*i +: 2]; 00 AND 01 OR 10 ADD 11 SUB
//  gnt        out  N       one-hot, 1-cycle pulse: operands of requester i captured
//  res_valid  out  1       result available
//  res_ready  in   1       consumer accepts result when res_valid & res_ready
//  res_id     out  $clog2(N)  index of requester owning the result
//  res_data   out  W       result
//  res_ovf    out  1       signed overflow of ADD/SUB; 0 for AND/OR
//  busy       out  1       1 in EXEC or RESP
// BEHAVIOUR
//  - Clock clk; reset rst_n is asynchronous, active-low. Reset (incl. mid-op)
//    clears gnt, res_valid, res_id, res_data, res_ovf and busy to 0; state=IDLE;
//    RR pointer=0 (requester 0 highest priority). Any op in flight is dropped.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//    IDLE: if |req, pick first asserted req starting at ptr (wrapping N-1 -> 0);
//          pulse gnt[win], latch A/B/F/id, ptr <= win+1 mod N, go EXEC. Else stay.
//    EXEC: compute via ula_core; register res_data/res_ovf/res_id; go RESP.
//    RESP: res_valid=1; outputs stable until handshake; on res_ready go IDLE.
//  - Latency: gnt at cycle t, res_valid at t+2. Throughput: 1 op / 3 cycles
//    without backpressure. No new gnt while busy.
//  - A req dropped before gnt is ignored (no grant, no result). Ops on
//    unrequested inputs never start.
//  - Arithmetic: W-bit wrap. ADD ovf = (A[W-1]==B[W-1]) & (Y[W-1]!=A[W-1]);
//    SUB ovf = (A[W-1]!=B[W-1]) & (Y[W-1]!=A[W-1]). AND/OR ovf=0.
//  - Simultaneous res_ready and new req in RESP: result retires, grant happens
//    the next cycle in IDLE (no bypass).
// CONFIGURATION
//  ULA_SAT_EN defined: ADD/SUB with ovf=1 saturate res_data to 2^(W-1)-1 if A
//    non-negative, else -2^(W-1); res_ovf still reports 1.
//  ULA_SAT_EN undefined: res_data is the wrapped W-bit result.
// STRUCTURE
//  - ula_pkg: typedef enum logic [1:0] {OP_AND,OP_OR,OP_ADD,OP_SUB} ula_op_t;
//    typedef enum {S_IDLE,S_EXEC,S_RESP} ula_arb_state_t.
//  - Sub-module ula_core #(W): combinational A,B,F -> Y,ovf (saturation included
//    under ULA_SAT_EN). ula_arbiter holds FSM, RR pointer and operand/result regs.
// TESTING
//  1. W=8, req0 F=AND A=0xF0 B=0x3C, res_ready=1 -> gnt=01 at t, t+2 res_data=0x30
//     ovf=0 id=0; repeat F=OR -> 0xFC ovf=0.
//  2. ADD A=100 B=50 -> res_data=0x96 ovf=1; with ULA_SAT_EN -> 0x7F ovf=1.
//  3. SUB A=-128 B=1 -> res_data=0x7F ovf=1; with ULA_SAT_EN -> 0x80 ovf=1;
//     SUB A=5 B=7 -> 0xFE ovf=0.
//  4. req=11 held constantly, res_ready=1 -> gnt sequence 01,10,01,10; res_id
//     alternates 0,1,0,1.
//  5. res_ready=0 for 5 cycles in RESP -> res_valid/res_data/res_id stable, no gnt,
//     busy=1; res_ready=1 -> retire, next gnt 1 cycle later.
//  6. rst_n low during EXEC -> all outputs 0 immediately (async); after release,
//     req=11 -> gnt=01 first.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared types for the ULA arbiter slice (ALU function codes, FSM states)
package ula_pkg;
    typedef enum logic [1:0] {OP_AND, OP_OR, OP_ADD, OP_SUB} ula_op_t;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} ula_arb_state_t;
endpackage

// File: rtl/ula_arbiter_if.sv
// ula_arbiter_if: request/operand inputs and tagged result bus between clients and the shared ALU
interface ula_arbiter_if #(parameter int W = 8, parameter int N = 2);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [2*N-1:0] op_f;
    logic [N-1:0]   gnt;
    logic           res_valid;
    logic           res_ready;
    logic [IW-1:0]  res_id;
    logic [W-1:0]   res_data;
    logic           res_ovf;
    logic           busy;
    modport master (output req, op_a, op_b, op_f, res_ready,
                    input  gnt, res_valid, res_id, res_data, res_ovf, busy);
    modport slave  (input  req, op_a, op_b, op_f, res_ready,
                    output gnt, res_valid, res_id, res_data, res_ovf, busy);
endinterface

// File: rtl/ula_core.sv
// ula_core: combinational AND/OR/ADD/SUB with signed overflow; saturates on overflow when ULA_SAT_EN is defined
module ula_core import ula_pkg::*; #(parameter int W = 8) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  ula_op_t      f,
    output logic [W-1:0] y,
    output logic         ovf
);
    logic [W-1:0] sum, dif, raw;
    assign sum = a + b;
    assign dif = a - b;
    assign raw = (f == OP_AND) ? (a & b) : (f == OP_OR) ? (a | b) : (f == OP_ADD) ? sum : dif;
    assign ovf = (f == OP_ADD) ? ((a[W-1] == b[W-1]) && (sum[W-1] != a[W-1])) :
                 (f == OP_SUB) ? ((a[W-1] != b[W-1]) && (dif[W-1] != a[W-1])) : 1'b0;
`ifdef ULA_SAT_EN
    // overflow direction follows the sign of A: non-negative A can only overflow upward
    assign y = ovf ? (a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : raw;
`else
    assign y = raw;
`endif
endmodule

// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin sharing of one ula_core among N requesters (optional ULA_SAT_EN saturation)
module ula_arbiter import ula_pkg::*; #(parameter int W = 8, parameter int N = 2) (
    input logic        clk,
    input logic        rst_n,
    ula_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    ula_arb_state_t state;
    logic [IW-1:0]  ptr, win, id_q;
    logic           hit, ovf;
    logic [W-1:0]   a_q, b_q, y;
    ula_op_t        f_q;

    // first asserted request at or after the RR pointer, wrapping around
    always_comb begin
        int idx;
        win = '0;
        hit = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (bus.req[idx]) begin
                win = IW'(idx);
                hit = 1'b1;
            end
        end
    end

    assign bus.gnt       = (rst_n && state == S_IDLE && hit) ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
    assign bus.busy      = state != S_IDLE;
    assign bus.res_valid = state == S_RESP;

    ula_core #(.W(W)) u_core (.a(a_q), .b(b_q), .f(f_q), .y(y), .ovf(ovf));

    // FSM: capture operands on grant, register the ALU result, hold it until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ptr          <= '0;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            f_q          <= OP_AND;
            bus.res_id   <= '0;
            bus.res_data <= '0;
            bus.res_ovf  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (hit) begin
                    a_q   <= bus.op_a[int'(win)*W +: W];
                    b_q   <= bus.op_b[int'(win)*W +: W];
                    f_q   <= ula_op_t'(bus.op_f[int'(win)*2 +: 2]);
                    id_q  <= win;
                    ptr   <= IW'((int'(win) + 1) % N);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    bus.res_data <= y;
                    bus.res_ovf  <= ovf;
                    bus.res_id   <= id_q;
                    state        <= S_RESP;
                end
                S_RESP: if (bus.res_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_arbiter.sv
// tb_ula_arbiter: randomized and directed checks of ula_arbiter against an integer-arithmetic reference model
module tb_ula_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int mptr = 0;

    ula_arbiter_if #(.W(8), .N(2)) bus();
    ula_arbiter #(.W(8), .N(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f,
                                    output logic [7:0] y, output logic o);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = (f == 2'd2) ? sa + sb : sa - sb;
        if (f == 2'd0) begin
            y = a & b;
            o = 1'b0;
        end else if (f == 2'd1) begin
            y = a | b;
            o = 1'b0;
        end else begin
            o = (r > 127) || (r < -128);
`ifdef ULA_SAT_EN
            y = o ? ((r > 0) ? 8'h7f : 8'h80) : r[7:0];
`else
            y = r[7:0];
`endif
        end
    endfunction

    task automatic test_reset();
        bus.req = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.op_f = '0;
        bus.res_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt); end
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.res_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.res_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.res_data); end
        total++; if (bus.res_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.res_ovf); end
        total++; if (bus.res_id !== 1'b0) begin bad++; $display("FAIL reset_id got=%b exp=0", bus.res_id); end
        step();
        rst_n = 1'b1;
        mptr = 0;
    endtask

    task automatic do_op(input int id, input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] ey;
        logic eo;
        logic [1:0] oh;
        ref_alu(a, b, f, ey, eo);
        oh = 2'b01 << id;
        bus.req = '0;
        bus.req[id] = 1'b1;
        bus.op_a[id*8 +: 8] = a;
        bus.op_b[id*8 +: 8] = b;
        bus.op_f[id*2 +: 2] = f;
        @(negedge clk);
        total++; if (bus.gnt !== oh) begin bad++; $display("FAIL op_gnt got=%b exp=%b", bus.gnt, oh); end
        step();
        bus.req[id] = 1'b0;
        @(negedge clk);
        total++; if ({bus.gnt, bus.busy, bus.res_valid} !== 4'b0010) begin
            bad++; $display("FAIL op_exec gnt/busy/valid got=%b exp=0010", {bus.gnt, bus.busy, bus.res_valid}); end
        step();
        @(negedge clk);
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL op_valid got=%b exp=1", bus.res_valid); end
        total++; if (bus.res_data !== ey) begin bad++; $display("FAIL op_data f=%0d a=%h b=%h got=%h exp=%h", f, a, b, bus.res_data, ey); end
        total++; if (bus.res_ovf !== eo) begin bad++; $display("FAIL op_ovf f=%0d a=%h b=%h got=%b exp=%b", f, a, b, bus.res_ovf, eo); end
        total++; if (bus.res_id !== 1'(id)) begin bad++; $display("FAIL op_id got=%0d exp=%0d", bus.res_id, id); end
        step();
        mptr = (id + 1) % 2;
        @(negedge clk);
        total++; if ({bus.res_valid, bus.busy} !== 2'b00) begin
            bad++; $display("FAIL op_retire valid/busy got=%b exp=00", {bus.res_valid, bus.busy}); end
        step();
    endtask

    task automatic test_directed();
        do_op(0, 2'd0, 8'hF0, 8'h3C);
        do_op(0, 2'd1, 8'hF0, 8'h3C);
        do_op(0, 2'd2, 8'd100, 8'd50);
        do_op(1, 2'd3, 8'h80, 8'h01);
        do_op(1, 2'd3, 8'd5, 8'd7);
        do_op(1, 2'd2, 8'h80, 8'hFF);
    endtask

    task automatic test_random();
        repeat (40) do_op(int'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_round_robin();
        int p;
        int qid[$];
        logic [7:0] qy[$];
        logic qo[$];
        logic [7:0] ey;
        logic eo;
        logic [1:0] eg;
        int k;
        p = mptr;
        bus.op_a = 16'($urandom);
        bus.op_b = 16'($urandom);
        bus.op_f = 4'($urandom);
        bus.req = 2'b11;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            eg = (c % 3 == 0) ? (2'b01 << p) : 2'b00;
            total++; if (bus.gnt !== eg) begin bad++; $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", c, bus.gnt, eg); end
            if (c % 3 == 0) begin
                ref_alu(bus.op_a[p*8 +: 8], bus.op_b[p*8 +: 8], bus.op_f[p*2 +: 2], ey, eo);
                qid.push_back(p);
                qy.push_back(ey);
                qo.push_back(eo);
                p = (p + 1) % 2;
            end
            total++; if (bus.res_valid !== (c % 3 == 2)) begin bad++; $display("FAIL rr_valid cycle=%0d got=%b", c, bus.res_valid); end
            if (c % 3 == 2 && qid.size() > 0) begin
                total++; if (bus.res_id !== 1'(qid[0])) begin bad++; $display("FAIL rr_id got=%0d exp=%0d", bus.res_id, qid[0]); end
                total++; if (bus.res_data !== qy[0]) begin bad++; $display("FAIL rr_data got=%h exp=%h", bus.res_data, qy[0]); end
                total++; if (bus.res_ovf !== qo[0]) begin bad++; $display("FAIL rr_ovf got=%b exp=%b", bus.res_ovf, qo[0]); end
                void'(qid.pop_front());
                void'(qy.pop_front());
                void'(qo.pop_front());
            end
            step();
            bus.op_a = 16'($urandom);
            bus.op_b = 16'($urandom);
            bus.op_f = 4'($urandom);
        end
        mptr = p;
        bus.req = 2'b00;
        k = 0;
        while (bus.busy && k < 10) begin
            step();
            k++;
        end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rr_drain busy got=%b exp=0", bus.busy); end
        step();
    endtask

    task automatic test_backpressure();
        logic [7:0] ey, ey1;
        logic eo, eo1;
        bus.res_ready = 1'b0;
        bus.req = 2'b01;
        bus.op_a[7:0] = 8'd60;
        bus.op_b[7:0] = 8'd70;
        bus.op_f[1:0] = 2'd2;
        ref_alu(8'd60, 8'd70, 2'd2, ey, eo);
        @(negedge clk);
        total++; if (bus.gnt !== 2'b01) begin bad++; $display("FAIL bp_gnt0 got=%b exp=01", bus.gnt); end
        step();
        bus.req = 2'b10;
        bus.op_a[15:8] = 8'h0F;
        bus.op_b[15:8] = 8'h33;
        bus.op_f[3:2] = 2'd1;
        ref_alu(8'h0F, 8'h33, 2'd1, ey1, eo1);
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if ({bus.res_valid, bus.busy, bus.gnt} !== 4'b1100) begin
                bad++; $display("FAIL bp_hold cycle=%0d valid/busy/gnt got=%b exp=1100", c, {bus.res_valid, bus.busy, bus.gnt}); end
            total++; if ({bus.res_id, bus.res_data, bus.res_ovf} !== {1'b0, ey, eo}) begin
                bad++; $display("FAIL bp_stable cycle=%0d got=%h exp=%h", c, {bus.res_id, bus.res_data, bus.res_ovf}, {1'b0, ey, eo}); end
            step();
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL bp_last_valid got=%b exp=1", bus.res_valid); end
        step();
        @(negedge clk);
        total++; if ({bus.res_valid, bus.gnt} !== 3'b010) begin
            bad++; $display("FAIL bp_next_gnt valid/gnt got=%b exp=010", {bus.res_valid, bus.gnt}); end
        step();
        bus.req = 2'b00;
        step();
        @(negedge clk);
        total++; if ({bus.res_valid, bus.res_id, bus.res_data, bus.res_ovf} !== {2'b11, ey1, eo1}) begin
            bad++; $display("FAIL bp_second got=%h exp=%h", {bus.res_valid, bus.res_id, bus.res_data, bus.res_ovf}, {2'b11, ey1, eo1}); end
        step();
        mptr = 0;
        step();
    endtask

    task automatic test_reset_mid();
        bus.req = 2'b01;
        bus.op_a[7:0] = 8'd1;
        bus.op_b[7:0] = 8'd2;
        bus.op_f[1:0] = 2'd2;
        @(negedge clk);
        total++; if (bus.gnt !== 2'b01) begin bad++; $display("FAIL rst_pre_gnt got=%b exp=01", bus.gnt); end
        step();
        rst_n = 1'b0;
        bus.req = 2'b11;
        #1;
        total++; if ({bus.gnt, bus.res_valid, bus.busy, bus.res_ovf, bus.res_id} !== 6'b0) begin
            bad++; $display("FAIL rst_async_ctl got=%b exp=000000", {bus.gnt, bus.res_valid, bus.busy, bus.res_ovf, bus.res_id}); end
        total++; if (bus.res_data !== 8'h00) begin bad++; $display("FAIL rst_async_data got=%h exp=00", bus.res_data); end
        step();
        step();
        rst_n = 1'b1;
        bus.op_f = 4'b0000;
        bus.op_a = 16'h0F0F;
        bus.op_b = 16'hFFFF;
        @(negedge clk);
        total++; if (bus.gnt !== 2'b01) begin bad++; $display("FAIL rst_first_gnt got=%b exp=01", bus.gnt); end
        step();
        bus.req = 2'b00;
        step();
        @(negedge clk);
        total++; if ({bus.res_valid, bus.res_id, bus.res_data} !== {2'b10, 8'h0F}) begin
            bad++; $display("FAIL rst_first_res got=%h exp=%h", {bus.res_valid, bus.res_id, bus.res_data}, {2'b10, 8'h0F}); end
        step();
        mptr = 1;
        step();
    endtask

    task automatic test_dropped_req();
        bus.req = 2'b01;
        #2;
        bus.req = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if ({bus.gnt, bus.busy, bus.res_valid} !== 4'b0000) begin
                bad++; $display("FAIL drop cycle=%0d gnt/busy/valid got=%b exp=0000", c, {bus.gnt, bus.busy, bus.res_valid}); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_dropped_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
